// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: refresh prescaler, frame-synchronous commit of
// CPU writes, and registered anode/segment outputs. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clck_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [15:0] wr_data_i,
  input  logic [3:0]  dp_wr_i,
  input  logic        blank_i,
  input  logic [1:0]  digit_sel_i,
  output logic        scan_tick_o,
  output logic        pending_o,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] r_presc;
  logic            r_tick;
  logic [1:0]      r_prev_sel;
  logic [15:0]     r_shadow_data;
  logic [3:0]      r_shadow_dp;
  logic [15:0]     r_active_data;
  logic [3:0]      r_active_dp;
  logic            r_pending;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_boundary;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg;
  logic [3:0]      w_an;
  logic [3:0]      w_lzb_mask;

  assign w_boundary = (r_prev_sel == 2'd3) && (digit_sel_i == 2'd0);

  always_ff @(posedge clck_i) begin
    if (rst_i) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= (r_presc == CntMax) ? '0 : r_presc + 1'b1;
      r_tick  <= (r_presc == CntMax);
    end
  end

  // A write coincident with a commit: active takes the old shadow, new data stays pending.
  always_ff @(posedge clck_i) begin
    if (rst_i) begin
      r_prev_sel    <= 2'd0;
      r_shadow_data <= 16'h0000;
      r_shadow_dp   <= 4'h0;
      r_active_data <= 16'h0000;
      r_active_dp   <= 4'h0;
      r_pending     <= 1'b0;
    end else begin
      r_prev_sel <= digit_sel_i;
      if (w_boundary && r_pending) begin
        r_active_data <= r_shadow_data;
        r_active_dp   <= r_shadow_dp;
      end
      if (wr_en_i) begin
        r_shadow_data <= wr_data_i;
        r_shadow_dp   <= dp_wr_i;
        r_pending     <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_nib = r_active_data[{digit_sel_i, 2'b00} +: 4];
    w_seg = 7'b1111111;
    unique case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_comb begin
    w_lzb_mask    = 4'b0000;
`ifdef SEG7_LZB_EN
    // Digit k goes dark when it and every digit to its left is zero with no decimal point.
    w_lzb_mask[1] = (r_active_data[15:4] == 12'h000) && !r_active_dp[1];
    w_lzb_mask[2] = (r_active_data[15:8] == 8'h00) && !r_active_dp[2];
    w_lzb_mask[3] = (r_active_data[15:12] == 4'h0) && !r_active_dp[3];
`endif
    w_an = ~(4'b0001 << digit_sel_i) | w_lzb_mask;
  end

  always_ff @(posedge clck_i) begin
    if (rst_i || blank_i) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= ~r_active_dp[digit_sel_i];
    end
  end

  assign scan_tick_o = r_tick;
  assign pending_o   = r_pending;
  assign an_o        = r_an;
  assign seg_o       = r_seg;
  assign dp_o        = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with PRESCALE=4; the scan counter is driven by hand.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  dp_wr;
  logic        blank;
  logic [1:0]  sel;
  logic        tick;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  seg7_scan_driver #(.PRESCALE(4)) dut (
    .clck_i      (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .dp_wr_i     (dp_wr),
    .blank_i     (blank),
    .digit_sel_i (sel),
    .scan_tick_o (tick),
    .pending_o   (pending),
    .an_o        (an),
    .seg_o       (seg),
    .dp_o        (dp)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] v);
    sel = v;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs an=%h seg=%b dp=%b want an=f seg=1111111 dp=1", an, seg, dp);
    end
    checks++;
    if (pending !== 1'b0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags pending=%b tick=%b want 0 0", pending, tick);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      checks++;
      if (tick !== (k % 4 == 0)) begin
        failures++;
        $display("FAIL tick_cycle_%0d got=%b want=%b", k, tick, (k % 4 == 0));
      end
    end
  endtask

  task automatic test_write_commit();
    wr_en = 1'b1; wr_data = 16'h1234; dp_wr = 4'h0;
    cyc();
    wr_en = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL pending_rise got=%b want=1", pending);
    end
    set_sel(2'd1);
    set_sel(2'd2);
    set_sel(2'd3);
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL pending_hold got=%b want=1", pending);
    end
    set_sel(2'd0);
    checks++;
    if (pending !== 1'b0 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL commit_edge pending=%b seg=%b want 0 1000000", pending, seg);
    end
    set_sel(2'd0);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0011001 || dp !== 1'b1) begin
      failures++;
      $display("FAIL digit0_1234 an=%b seg=%b dp=%b want 1110 0011001 1", an, seg, dp);
    end
    set_sel(2'd1);
    set_sel(2'd2);
    set_sel(2'd3);
    checks++;
    if (an !== 4'b0111 || seg !== 7'b1111001) begin
      failures++;
      $display("FAIL digit3_1234 an=%b seg=%b want 0111 1111001", an, seg);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_data = 16'hAAAA;
    set_sel(2'd3);
    wr_data = 16'h00F0;
    set_sel(2'd3);
    wr_en = 1'b0;
    set_sel(2'd0);
    set_sel(2'd1);
    checks++;
    if (an !== 4'b1101 || seg !== 7'b0001110 || pending !== 1'b0) begin
      failures++;
      $display("FAIL last_write_wins an=%b seg=%b pending=%b want 1101 0001110 0", an, seg,
               pending);
    end
  endtask

  task automatic test_coincident();
    wr_en = 1'b1; wr_data = 16'h1111;
    set_sel(2'd2);
    wr_en = 1'b0;
    set_sel(2'd3);
    wr_en = 1'b1; wr_data = 16'h2222;
    set_sel(2'd0);
    wr_en = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL coincident_pending got=%b want=1", pending);
    end
    set_sel(2'd0);
    checks++;
    if (seg !== 7'b1111001) begin
      failures++;
      $display("FAIL coincident_old_d0 seg=%b want 1111001", seg);
    end
    set_sel(2'd1);
    set_sel(2'd2);
    set_sel(2'd3);
    checks++;
    if (seg !== 7'b1111001 || pending !== 1'b1) begin
      failures++;
      $display("FAIL coincident_old_d3 seg=%b pending=%b want 1111001 1", seg, pending);
    end
    set_sel(2'd0);
    set_sel(2'd0);
    checks++;
    if (seg !== 7'b0100100 || pending !== 1'b0) begin
      failures++;
      $display("FAIL coincident_new seg=%b pending=%b want 0100100 0", seg, pending);
    end
  endtask

  task automatic test_blank();
    blank = 1'b1;
    set_sel(2'd1);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL blank_outputs an=%h seg=%b dp=%b want f 1111111 1", an, seg, dp);
    end
    wr_en = 1'b1; wr_data = 16'h0005; dp_wr = 4'h0;
    set_sel(2'd2);
    wr_en = 1'b0;
    set_sel(2'd3);
    set_sel(2'd0);
    checks++;
    if (pending !== 1'b0 || an !== 4'hF) begin
      failures++;
      $display("FAIL blank_commit pending=%b an=%h want 0 f", pending, an);
    end
    blank = 1'b0;
    set_sel(2'd0);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0010010) begin
      failures++;
      $display("FAIL unblank_d0 an=%b seg=%b want 1110 0010010", an, seg);
    end
  endtask

  task automatic test_lzb();
    logic [3:0] exp_an1;
    logic [3:0] exp_an3;
`ifdef SEG7_LZB_EN
    exp_an1 = 4'b1111;
    exp_an3 = 4'b1111;
`else
    exp_an1 = 4'b1101;
    exp_an3 = 4'b0111;
`endif
    wr_en = 1'b1; wr_data = 16'h0005; dp_wr = 4'b0100;
    set_sel(2'd1);
    wr_en = 1'b0;
    set_sel(2'd2);
    set_sel(2'd3);
    set_sel(2'd0);
    set_sel(2'd0);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0010010 || dp !== 1'b1) begin
      failures++;
      $display("FAIL lzb_d0 an=%b seg=%b dp=%b want 1110 0010010 1", an, seg, dp);
    end
    set_sel(2'd1);
    checks++;
    if (an !== exp_an1) begin
      failures++;
      $display("FAIL lzb_d1 an=%b want %b", an, exp_an1);
    end
    set_sel(2'd2);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b1000000 || dp !== 1'b0) begin
      failures++;
      $display("FAIL lzb_d2 an=%b seg=%b dp=%b want 1011 1000000 0", an, seg, dp);
    end
    set_sel(2'd3);
    checks++;
    if (an !== exp_an3) begin
      failures++;
      $display("FAIL lzb_d3 an=%b want %b", an, exp_an3);
    end
  endtask

  task automatic test_reset_midframe();
    wr_en = 1'b1; wr_data = 16'h8888; dp_wr = 4'hF;
    set_sel(2'd1);
    wr_en = 1'b0;
    rst = 1'b1;
    set_sel(2'd2);
    cyc();
    checks++;
    if (pending !== 1'b0 || an !== 4'hF || tick !== 1'b0) begin
      failures++;
      $display("FAIL midreset pending=%b an=%h tick=%b want 0 f 0", pending, an, tick);
    end
    rst = 1'b0;
    sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (tick !== (k == 4)) begin
        failures++;
        $display("FAIL midreset_tick_%0d got=%b want=%b", k, tick, (k == 4));
      end
    end
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      failures++;
      $display("FAIL midreset_cleared an=%b seg=%b dp=%b want 1110 1000000 1", an, seg, dp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 16'h0000; dp_wr = 4'h0; blank = 1'b0; sel = 2'd0;
    test_reset();
    test_write_commit();
    test_back_to_back();
    test_coincident();
    test_blank();
    test_lzb();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
